// File: rtl/counter_capture_unit.sv
// Timestamp/compare/capture stage behind a 16-bit free-running counter.
// Optional macro CAP_BOTH_EDGES_EN: capture both event edges and tag each entry with its polarity.
module counter_capture_unit #(
    parameter int EPOCH_W    = 16,
    parameter int FIFO_DEPTH = 4,
`ifdef CAP_BOTH_EDGES_EN
    localparam int CAP_W     = EPOCH_W + 17
`else
    localparam int CAP_W     = EPOCH_W + 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      count,
    input  logic             overflow,
    input  logic [15:0]      cmp_val,
    input  logic             evt_in,
    output logic             cmp_match,
    output logic             cap_valid,
    input  logic             cap_ready,
    output logic [CAP_W-1:0] cap_data,
    output logic             cap_drop
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               cmp_match_q, cmp_match_d;
    logic               evt_s1_q, evt_s1_d;
    logic               evt_s2_q, evt_s2_d;
    logic               evt_prev_q, evt_prev_d;
    logic [CAP_W-1:0]   mem_q [FIFO_DEPTH];
    logic [CAP_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               cap_valid_q, cap_valid_d;
    logic [CAP_W-1:0]   cap_data_q, cap_data_d;
    logic               cap_drop_q, cap_drop_d;

    logic               rise_s;
    logic               detect_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic [CAP_W-1:0]   push_data_s;
`ifdef CAP_BOTH_EDGES_EN
    logic               fall_s;
`endif

    // Edge detection on the synchronised event and FIFO handshake decisions
    always_comb begin
        rise_s      = evt_s2_q & ~evt_prev_q;
`ifdef CAP_BOTH_EDGES_EN
        fall_s      = ~evt_s2_q & evt_prev_q;
        detect_s    = rise_s | fall_s;
        push_data_s = {rise_s, epoch_q, count};
`else
        detect_s    = rise_s;
        push_data_s = {epoch_q, count};
`endif
        pop_s  = cap_valid_q & cap_ready;
        full_s = (occ_q == OCC_W'(FIFO_DEPTH));
        // A full FIFO still takes the event when the head leaves in the same cycle
        push_s = detect_s & (~full_s | pop_s);
    end

    // Next-state computation for epoch, compare, synchroniser and FIFO
    always_comb begin
        if (overflow) begin
            epoch_d = epoch_q + EPOCH_W'(1);
        end else begin
            epoch_d = epoch_q;
        end
        cmp_match_d = (count == cmp_val);
        evt_s1_d    = evt_in;
        evt_s2_d    = evt_s1_q;
        evt_prev_d  = evt_s2_q;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = push_data_s;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // Head is registered from next state, so an empty-FIFO push shows one cycle later
        cap_valid_d = (occ_d != OCC_W'(0));
        cap_data_d  = mem_d[rd_ptr_d];
        cap_drop_d  = detect_s & full_s & ~pop_s;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            epoch_q     <= '0;
            cmp_match_q <= 1'b0;
            evt_s1_q    <= 1'b0;
            evt_s2_q    <= 1'b0;
            evt_prev_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            occ_q       <= '0;
            cap_valid_q <= 1'b0;
            cap_data_q  <= '0;
            cap_drop_q  <= 1'b0;
        end else begin
            epoch_q     <= epoch_d;
            cmp_match_q <= cmp_match_d;
            evt_s1_q    <= evt_s1_d;
            evt_s2_q    <= evt_s2_d;
            evt_prev_q  <= evt_prev_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            cap_valid_q <= cap_valid_d;
            cap_data_q  <= cap_data_d;
            cap_drop_q  <= cap_drop_d;
        end
    end

    assign cmp_match = cmp_match_q;
    assign cap_valid = cap_valid_q;
    assign cap_data  = cap_data_q;
    assign cap_drop  = cap_drop_q;

endmodule

// File: tb/tb_counter_capture_unit.sv
// Directed bench for counter_capture_unit: bench drives the counter, a queue holds expected captures.
module tb_counter_capture_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] count;
    logic        overflow;
    logic [15:0] cmp_val;
    logic        evt_in;
    logic        cmp_match;
    logic        cap_valid;
    logic        cap_ready;
    logic [31:0] cap_data;
    logic        cap_drop;

    int          n_checks;
    int          n_fail;
    int          cmp_pulses;
    int          drop_pulses;
    bit          cnt_run;
    logic [15:0] ep_model;
    logic [31:0] sb[$];

    counter_capture_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count     (count),
        .overflow  (overflow),
        .cmp_val   (cmp_val),
        .evt_in    (evt_in),
        .cmp_match (cmp_match),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .cap_data  (cap_data),
        .cap_drop  (cap_drop)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare any pop against the scoreboard, advance the counter model
    task automatic tick();
        logic ov;
        logic rs;
        ov = overflow;
        rs = rst_n;
        if (cap_valid === 1'b1 && cap_ready === 1'b1) begin
            if (sb.size() == 0) chk("pop_unexpected", 64'(cap_data), 64'hdead);
            else                chk("pop_data", 64'(cap_data), 64'(sb.pop_front()));
        end
        @(posedge clk);
        #1;
        if (ov && rs) ep_model = ep_model + 16'd1;
        if (cnt_run) count = count + 16'd1;
        overflow = (count == 16'hffff);
        if (cmp_match === 1'b1) cmp_pulses++;
        if (cap_drop === 1'b1) drop_pulses++;
    endtask

    // One-cycle event pulse, optionally expecting it in the FIFO; detect is two cycles later
    task automatic pulse_evt(input bit expect_push);
        if (expect_push) sb.push_back({ep_model, count} + 32'd2);
        evt_in = 1'b1;
        tick();
        evt_in = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cmp_pulses = 0; drop_pulses = 0;
        ep_model = 16'd0; cnt_run = 1'b0;
        rst_n = 1'b0; count = 16'd0; overflow = 1'b0;
        cmp_val = 16'h000a; evt_in = 1'b0; cap_ready = 1'b0;

        repeat (4) tick();
        chk("rst_cap_valid", 64'(cap_valid), 64'd0);
        chk("rst_cmp_match", 64'(cmp_match), 64'd0);
        chk("rst_cap_drop",  64'(cap_drop),  64'd0);
        chk("rst_cap_data",  64'(cap_data),  64'd0);

        rst_n = 1'b1; cnt_run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("cmp_match_seq", 64'(cmp_match), 64'(count == 16'h000b));
            if (i < 4) chk("idle_cap_valid", 64'(cap_valid), 64'd0);
        end
        chk("cmp_single_pulse", 64'(cmp_pulses), 64'd1);

        // Latency: event at count 0x0100, visible three cycles later
        cap_ready = 1'b1;
        repeat (16'h0100 - count) tick();
        pulse_evt(1'b1);
        chk("lat_valid_c1", 64'(cap_valid), 64'd0);
        tick();
        chk("lat_valid_c2", 64'(cap_valid), 64'd0);
        tick();
        chk("lat_valid_c3", 64'(cap_valid), 64'd1);
        chk("lat_data", 64'(cap_data), 64'h0000_0102);
        tick();
        chk("lat_drained", 64'(cap_valid), 64'd0);

        // Full/drop: five events with consumer stalled
        cap_ready = 1'b0; drop_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            pulse_evt(i < 4);
            repeat (3) tick();
        end
        chk("full_drop_once", 64'(drop_pulses), 64'd1);
        chk("full_valid", 64'(cap_valid), 64'd1);
        cap_ready = 1'b1;
        repeat (4) tick();
        chk("full_drain_empty", 64'(cap_valid), 64'd0);
        chk("full_sb_empty", 64'(sb.size()), 64'd0);

        // Full FIFO with pop in the detect cycle: no drop, occupancy stays 4
        cap_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse_evt(1'b1);
            repeat (3) tick();
        end
        drop_pulses = 0;
        pulse_evt(1'b1);
        tick();
        cap_ready = 1'b1;
        tick();
        cap_ready = 1'b0;
        repeat (3) tick();
        chk("bp_no_drop", 64'(drop_pulses), 64'd0);
        chk("bp_valid", 64'(cap_valid), 64'd1);
        cap_ready = 1'b1;
        repeat (4) tick();
        chk("bp_drain_empty", 64'(cap_valid), 64'd0);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Reset mid-operation discards queued entries
        cap_ready = 1'b0;
        pulse_evt(1'b0);
        repeat (3) tick();
        pulse_evt(1'b0);
        repeat (3) tick();
        chk("pre_rst_valid", 64'(cap_valid), 64'd1);
        rst_n = 1'b0; cnt_run = 1'b0; count = 16'd0; overflow = 1'b0;
        repeat (2) tick();
        ep_model = 16'd0;
        chk("midrst_valid", 64'(cap_valid), 64'd0);
        chk("midrst_data", 64'(cap_data), 64'd0);
        rst_n = 1'b1; cnt_run = 1'b1; cmp_pulses = 0;
        repeat (3) tick();
        chk("post_rst_valid", 64'(cap_valid), 64'd0);

        // Epoch wrap: run through a full lap, event in the cycle after overflow
        repeat (16'hffff - count) tick();
        chk("ovf_at_ffff", 64'(overflow), 64'd1);
        tick();
        chk("wrap_count", 64'(count), 64'd0);
        cap_ready = 1'b1;
        pulse_evt(1'b1);
        tick();
        tick();
        chk("wrap_valid", 64'(cap_valid), 64'd1);
        chk("wrap_data", 64'(cap_data), 64'h0001_0002);
        tick();
        chk("wrap_sb_empty", 64'(sb.size()), 64'd0);
        chk("lap_one_pulse", 64'(cmp_pulses), 64'd1);
        repeat (16'h0020 - count) tick();
        chk("lap_two_pulses", 64'(cmp_pulses), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
